// File: rtl/embertrail_data_mem.sv
// embertrail_data_mem: dual-lane 16-bit data memory with a post-reset clear sequencer and 1-cycle read latency.
// Optional macro EMBERTRAIL_DMEM_BYPASS_EN forwards same-cycle write data to a colliding read.
`default_nettype none

module embertrail_data_mem #(
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [31:0] iDataAddrBus,
  input  logic [31:0] iDataDataBus,
  input  logic        iData1BusEn,
  input  logic        iData2BusEn,
  input  logic        iDataMem1RW,
  input  logic        iDataMem2RW,
  output logic [31:0] oDataDataBus,
  output logic        oData1Valid,
  output logic        oData2Valid,
  output logic        oReady
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_PEND  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              ready_q;
  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       rd1_q, rd2_q;
  logic [15:0]       rd1_d, rd2_d;
  logic              v1_q, v2_q;

  logic [ADDR_W-1:0] a1, a2;
  logic [15:0]       wd1, wd2;
  logic              wr1, wr2, rq1, rq2, clr_we;

  assign a1  = iDataAddrBus[ADDR_W-1:0];
  assign a2  = iDataAddrBus[16+ADDR_W-1:16];
  assign wd1 = iDataDataBus[15:0];
  assign wd2 = iDataDataBus[31:16];

  // Requests only count while ready and not being reset on this edge.
  assign wr1    = iReset & ready_q & iData1BusEn &  iDataMem1RW;
  assign wr2    = iReset & ready_q & iData2BusEn &  iDataMem2RW;
  assign rq1    = iReset & ready_q & iData1BusEn & ~iDataMem1RW;
  assign rq2    = iReset & ready_q & iData2BusEn & ~iDataMem2RW;
  assign clr_we = iReset & (state_q == ST_CLEAR);

  generate
    if (ADDR_W < 16) begin : g_addr_trunc
      logic unused_addr_hi;
      assign unused_addr_hi = ^{iDataAddrBus[31:16+ADDR_W], iDataAddrBus[15:ADDR_W]};
    end else begin : g_addr_full
    end
  endgenerate

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_PEND;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (&clr_cnt_q) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_PEND:  state_q <= ST_RUN;
        ST_RUN:   ready_q <= 1'b1;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  // Lane 2 is written last so it wins a same-address collision.
  always_ff @(posedge iClock) begin
    if (clr_we) mem_q[clr_cnt_q] <= 16'h0000;
    if (wr1)    mem_q[a1]        <= wd1;
    if (wr2)    mem_q[a2]        <= wd2;
  end

  always_comb begin
    rd1_d = mem_q[a1];
    rd2_d = mem_q[a2];
`ifdef EMBERTRAIL_DMEM_BYPASS_EN
    if (wr2 && (a2 == a1)) rd1_d = wd2;
    if (wr1 && (a1 == a2)) rd2_d = wd1;
`endif
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      rd1_q <= 16'h0000;
      rd2_q <= 16'h0000;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
    end else begin
      v1_q <= rq1;
      v2_q <= rq2;
      if (rq1) rd1_q <= rd1_d;
      if (rq2) rd2_q <= rd2_d;
    end
  end

  assign oDataDataBus = {rd2_q, rd1_q};
  assign oData1Valid  = v1_q;
  assign oData2Valid  = v2_q;
  assign oReady       = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_embertrail_data_mem.sv
// Testbench for embertrail_data_mem (ADDR_W=4, CLEAR_ON_RESET=1): directed steps plus random traffic vs a reference model.
`default_nettype none

module tb_embertrail_data_mem;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

`ifdef EMBERTRAIL_DMEM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        en1 = 1'b0, en2 = 1'b0, rw1 = 1'b0, rw2 = 1'b0;
  logic [31:0] dout;
  logic        v1, v2, rdy;

  logic [15:0] mdl [DEPTH];
  logic [15:0] e_lo = '0, e_hi = '0;
  logic        e_v1 = 1'b0, e_v2 = 1'b0, e_rdy = 1'b0;
  int          since_rel = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  embertrail_data_mem #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .iClock      (clk),
    .iReset      (rst_n),
    .iDataAddrBus(addr),
    .iDataDataBus(wdata),
    .iData1BusEn (en1),
    .iData2BusEn (en2),
    .iDataMem1RW (rw1),
    .iDataMem2RW (rw2),
    .oDataDataBus(dout),
    .oData1Valid (v1),
    .oData2Valid (v2),
    .oReady      (rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Predict the effect of the coming edge from the current inputs, then clock and compare.
  task automatic step();
    int  a1, a2;
    bit  r1, r2, w1, w2;
    a1 = int'(addr[15:0]) % DEPTH;
    a2 = int'(addr[31:16]) % DEPTH;
    r1 = en1 && !rw1;
    w1 = en1 && rw1;
    r2 = en2 && !rw2;
    w2 = en2 && rw2;
    if (!rst_n) begin
      e_lo = '0; e_hi = '0; e_v1 = 1'b0; e_v2 = 1'b0; e_rdy = 1'b0; since_rel = 0;
    end else if (!e_rdy) begin
      e_v1 = 1'b0; e_v2 = 1'b0;
      since_rel++;
      if (since_rel == DEPTH) begin
        e_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h0000;
      end
    end else begin
      if (r1) e_lo = (BYPASS && w2 && a2 == a1) ? wdata[31:16] : mdl[a1];
      if (r2) e_hi = (BYPASS && w1 && a1 == a2) ? wdata[15:0]  : mdl[a2];
      e_v1 = r1;
      e_v2 = r2;
      if (w1) mdl[a1] = wdata[15:0];
      if (w2) mdl[a2] = wdata[31:16];
    end
    @(posedge clk);
    #1;
    chk("ready", {31'd0, rdy}, {31'd0, e_rdy});
    chk("data",  dout, {e_hi, e_lo});
    chk("valid1", {31'd0, v1}, {31'd0, e_v1});
    chk("valid2", {31'd0, v2}, {31'd0, e_v2});
  endtask

  task automatic idle();
    en1   = 1'b0;
    en2   = 1'b0;
    rw1   = 1'($urandom);
    rw2   = 1'($urandom);
    addr  = $urandom;
    wdata = $urandom;
  endtask

  task automatic drive(input logic e1, input logic w1, input logic [15:0] ad1, input logic [15:0] d1,
                       input logic e2, input logic w2, input logic [15:0] ad2, input logic [15:0] d2);
    en1 = e1; rw1 = w1; en2 = e2; rw2 = w2;
    addr  = {ad2, ad1};
    wdata = {d2, d1};
  endtask

  initial begin
    logic [15:0] ra1, ra2;

    rst_n = 1'b0;
    idle();
    step();
    step();
    chk("reset_ready", {31'd0, rdy}, 32'd0);
    chk("reset_data", dout, 32'd0);

    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      if (i == DEPTH - 1) chk("ready_low_before_end", {31'd0, rdy}, 32'd0);
    end
    chk("ready_after_clear", {31'd0, rdy}, 32'd1);

    drive(1, 0, 16'd5, 16'h0000, 0, 0, 16'd0, 16'h0000);
    step();
    chk("rd5_data", {16'd0, dout[15:0]}, 32'h0000);
    chk("rd5_valid", {31'd0, v1}, 32'd1);
    idle();
    step();
    chk("valid_one_pulse", {31'd0, v1}, 32'd0);

    drive(1, 1, 16'd3, 16'hBEEF, 0, 0, 16'd0, 16'h0000);
    step();
    drive(0, 0, 16'd0, 16'h0000, 1, 0, 16'd3, 16'h0000);
    step();
    chk("lane2_rd3", {16'd0, dout[31:16]}, 32'h0000BEEF);
    chk("lane2_rd3_v2", {31'd0, v2}, 32'd1);
    chk("lane2_rd3_v1", {31'd0, v1}, 32'd0);
    chk("lane2_rd3_lo_hold", {16'd0, dout[15:0]}, 32'h0000);

    drive(1, 1, 16'd7, 16'h1111, 1, 1, 16'd7, 16'h2222);
    step();
    drive(1, 0, 16'd7, 16'h0000, 0, 0, 16'd0, 16'h0000);
    step();
    chk("lane2_wins", {16'd0, dout[15:0]}, 32'h2222);

    drive(1, 1, 16'd9, 16'hAAAA, 1, 0, 16'd9, 16'h0000);
    step();
    chk("rdw_collision", {16'd0, dout[31:16]}, BYPASS ? 32'hAAAA : 32'h0000);
    drive(0, 0, 16'd0, 16'h0000, 1, 0, 16'd9, 16'h0000);
    step();
    chk("rdw_later", {16'd0, dout[31:16]}, 32'hAAAA);

    drive(1, 1, 16'h0012, 16'h5A5A, 0, 0, 16'd0, 16'h0000);
    step();
    drive(0, 0, 16'd0, 16'h0000, 1, 0, 16'h0002, 16'h0000);
    step();
    chk("addr_wrap", {16'd0, dout[31:16]}, 32'h5A5A);

    for (int i = 0; i < 400; i++) begin
      ra1 = 16'($urandom);
      ra2 = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ra1[3:2] = 2'b00;
      if ($urandom_range(0, 1) == 1) ra2[3:2] = 2'b00;
      drive(1'($urandom), 1'($urandom), ra1, 16'($urandom),
            1'($urandom), 1'($urandom), ra2, 16'($urandom));
      step();
    end

    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1, 1, 16'd0, 16'hFFFF, 1, 1, 16'd1, 16'hFFFF);
      step();
      if (i == DEPTH - 1) chk("reclear_ready_low", {31'd0, rdy}, 32'd0);
    end
    chk("reclear_ready_high", {31'd0, rdy}, 32'd1);
    drive(1, 0, 16'd0, 16'h0000, 1, 0, 16'd1, 16'h0000);
    step();
    chk("clear_write_ignored0", {16'd0, dout[15:0]}, 32'h0000);
    chk("clear_write_ignored1", {16'd0, dout[31:16]}, 32'h0000);

    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/embertrail_data_mem.md
Name: embertrail_data_mem

Overview:
- Dual-lane data memory responder for the Embertrail control unit.
- Accepts two independent 16-bit access lanes per cycle (lane 1 = low halves of the buses, lane 2 = high halves) and performs the writes.
- Returns read data one cycle later on a 32-bit bus that feeds the controller's data-in.
- Contains a post-reset clear sequencer that zeroes the array before accepting traffic.

Parameters:
- ADDR_W, 8, word-address bits used per lane. Array depth = 2**ADDR_W words of 16 bits.
- CLEAR_ON_RESET, 1, when 1 the array is zeroed after reset. When 0 the block is ready one cycle after reset release and contents are undefined.

Ports:
- iClock  input  1  system clock, all logic on rising edge.
- iReset  input  1  synchronous, active-low reset.
- iDataAddrBus  input  32  [15:0] lane-1 word address, [31:16] lane-2 word address.
- iDataDataBus  input  32  [15:0] lane-1 write data, [31:16] lane-2 write data.
- iData1BusEn  input  1  lane-1 access request.
- iData2BusEn  input  1  lane-2 access request.
- iDataMem1RW  input  1  lane-1 direction: 1 = write, 0 = read.
- iDataMem2RW  input  1  lane-2 direction: 1 = write, 0 = read.
- oDataDataBus  output  32  [15:0] lane-1 read data, [31:16] lane-2 read data (registered).
- oData1Valid  output  1  one-cycle pulse: lane-1 read data valid.
- oData2Valid  output  1  one-cycle pulse: lane-2 read data valid.
- oReady  output  1  high when the block accepts requests.

Behaviour:
- Reset (iReset=0 at a clock edge): oDataDataBus=0, oData1Valid=0, oData2Valid=0, oReady=0, FSM→CLEAR (or RUN-pending if CLEAR_ON_RESET=0), clear counter=0. Array contents are not touched by reset itself.
- FSM states:
  - CLEAR: writes 16'h0000 to word[counter] each cycle; counter increments. After writing word DEPTH-1, go to RUN. Takes exactly DEPTH cycles; oReady=0 throughout.
  - RUN: oReady=1 and requests are serviced.
- CLEAR_ON_RESET=0: first cycle after reset release transitions directly to RUN. oReady=1 on the second edge after release.
- Reset asserted mid-CLEAR or mid-RUN: immediate return to the reset state. CLEAR restarts from word 0.
- Requests while oReady=0 are ignored: no write, no valid pulse.
- Address mapping: only the low ADDR_W bits of each lane address are used. Upper bits are ignored, so addresses wrap modulo DEPTH.
- Write (En=1, RW=1): array updated at the clock edge. No valid pulse.
- Read (En=1, RW=0): data registered at the request edge, so it appears on the lane's half of oDataDataBus with the Valid pulse in the next cycle. Latency = 1 cycle; lanes are fully independent.
- Lane read output holds its last read value when no read is issued. Valid is high only in the cycle following a read request.
- Read-during-write, same address, same cycle (either lane combination): read returns OLD data (read-first), unless the optional feature is enabled.
- Both lanes write the same address in the same cycle: lane 2 wins.
- Both lanes read the same address: both return identical data.
- En=0: RW and data are don't-care and have no side effects.

Optional Feature:
- Macro: EMBERTRAIL_DMEM_BYPASS_EN.
- Defined: same-cycle read/write collisions forward the write data.
  - A read whose address matches a same-cycle write returns the NEW write data.
  - If both lanes write that address, it returns lane-2 data.
- Not defined: read-first behaviour as above, with no forwarding logic synthesised.

Test Plan:
- Reset low 2 cycles, release, CLEAR_ON_RESET=1, ADDR_W=4 → oReady low for exactly 16 cycles then high. A subsequent lane-1 read of addr 5 returns 16'h0000 with oData1Valid pulse one cycle later.
- RUN: lane-1 write addr 3 = 16'hBEEF, next cycle lane-2 read addr 3 → oDataDataBus[31:16]=16'hBEEF, oData2Valid=1 for one cycle, oData1Valid=0, [15:0] unchanged.
- Same cycle: lane 1 writes addr 7 = 16'h1111, lane 2 writes addr 7 = 16'h2222; then read addr 7 → 16'h2222.
- Same cycle: lane 1 writes addr 9 = 16'hAAAA (old 16'h0000), lane 2 reads addr 9 → without macro 16'h0000, with EMBERTRAIL_DMEM_BYPASS_EN 16'hAAAA. A later read returns 16'hAAAA in both builds.
- ADDR_W=4: write addr 16'h0012 = 16'h5A5A, read addr 16'h0002 → 16'h5A5A (wrap).
- Assert reset at clear count 8, hold 1 cycle, release → oReady low a full 16 cycles again. Writes issued during CLEAR have no effect: read addr 0 → 16'h0000.
